// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL bring-up / reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    CPU_WAIT  = 3'd3,
    RUN       = 3'd4,
    LOST      = 3'd5
  } seq_state_e;

  localparam int unsigned RETRY_W = 4;

  // One counter serves every state, so size it for the longest interval.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the sequencer and the PLL / reset consumers.
interface pll_reset_sequencer_if;
  import pll_seq_pkg::*;

  logic               locked;
  logic               pll_resetb;
  logic               sys_reset;
  logic               cpu_reset;
  logic               ready;
  logic               lock_lost;
  logic [RETRY_W-1:0] retries;

  modport master (input locked, output pll_resetb, sys_reset, cpu_reset, ready, lock_lost, retries);
  modport slave  (output locked, input pll_resetb, sys_reset, cpu_reset, ready, lock_lost, retries);
endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs, clearable by synchronous reset.
module sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, waits for a stable lock, then releases system and CPU resets in order.
// Runs on the reference clock; re-enters the sequence whenever lock is lost.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 65535,
  parameter int unsigned CPU_DELAY      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  pll_reset_sequencer_if.master bus
);

  localparam int unsigned CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT, CPU_DELAY);

  localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CPU_LAST     = CNT_W'(CPU_DELAY - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = '1;

  seq_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic               lock_s;

  sync2 #(.W(1)) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.locked),
    .q     (lock_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= PLL_RST;
      cnt            <= '0;
      retry_cnt      <= '0;
      bus.pll_resetb <= 1'b0;
      bus.sys_reset  <= 1'b1;
      bus.cpu_reset  <= 1'b1;
      bus.ready      <= 1'b0;
      bus.lock_lost  <= 1'b0;
      bus.retries    <= '0;
    end else begin
      // Outputs follow the current state one cycle later.
      bus.pll_resetb <= (state != PLL_RST);
      bus.sys_reset  <= !(state == CPU_WAIT || state == RUN);
      bus.cpu_reset  <= (state != RUN);
      bus.ready      <= (state == RUN);
      bus.lock_lost  <= (state == LOST);
      bus.retries    <= retry_cnt;

      cnt <= (&cnt) ? cnt : cnt + CNT_W'(1);

      unique case (state)
        PLL_RST: begin
          if (cnt == PLL_RST_LAST) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state <= PLL_RST;
            cnt   <= '0;
            if (retry_cnt != RETRY_MAX) retry_cnt <= retry_cnt + RETRY_W'(1);
          end
        end
        STABLE: begin
          // Any dropout discards the accumulated stable time.
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state <= CPU_WAIT;
            cnt   <= '0;
          end
        end
        CPU_WAIT: begin
          if (!lock_s) begin
            state <= LOST;
            cnt   <= '0;
          end else if (cnt == CPU_LAST) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state <= LOST;
            cnt   <= '0;
          end
        end
        LOST: begin
          state <= PLL_RST;
          cnt   <= '0;
        end
        default: begin
          state <= PLL_RST;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed table of timed sequences plus randomized lock/reset traffic.
module tb_pll_reset_sequencer;

  localparam int PRC = 4;
  localparam int LS  = 8;
  localparam int LT  = 20;
  localparam int CD  = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pll_reset_sequencer_if bus_if ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES (PRC),
    .LOCK_STABLE    (LS),
    .LOCK_TIMEOUT   (LT),
    .CPU_DELAY      (CD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: phase + time spent in it, lock seen through a 2-deep delay line.
  typedef enum int {P_HOLD, P_SEEK, P_SETTLE, P_GRACE, P_UP, P_DROP} ph_e;
  ph_e ph;
  int  el;
  int  nretry;
  bit  hist[$];
  bit  e_pllrb, e_sys, e_cpu, e_rdy, e_lost;
  int  e_ret;
  bit  prev_lost;

  task automatic go(input ph_e p);
    ph = p;
    el = 0;
  endtask

  task automatic model_edge(input bit r, input bit l);
    bit ls;
    if (r) begin
      go(P_HOLD);
      nretry = 0;
      hist = '{1'b0, 1'b0};
      e_pllrb = 0; e_sys = 1; e_cpu = 1; e_rdy = 0; e_lost = 0; e_ret = 0;
      return;
    end
    ls = hist[0];
    void'(hist.pop_front());
    hist.push_back(l);
    e_pllrb = (ph != P_HOLD);
    e_sys   = !(ph == P_GRACE || ph == P_UP);
    e_cpu   = (ph != P_UP);
    e_rdy   = (ph == P_UP);
    e_lost  = (ph == P_DROP);
    e_ret   = nretry;
    el++;
    case (ph)
      P_HOLD:   if (el == PRC) go(P_SEEK);
      P_SEEK:   if (ls) go(P_SETTLE);
                else if (el == LT) begin go(P_HOLD); nretry = (nretry < 15) ? nretry + 1 : 15; end
      P_SETTLE: if (!ls) go(P_SEEK); else if (el == LS) go(P_GRACE);
      P_GRACE:  if (!ls) go(P_DROP); else if (el == CD) go(P_UP);
      P_UP:     if (!ls) go(P_DROP);
      default:  go(P_HOLD);
    endcase
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
    end
  endtask

  // One clock: drive at negedge, step model at posedge, compare at next negedge.
  task automatic cycle(input bit r, input bit l);
    reset = r;
    bus_if.locked = l;
    @(posedge clk);
    model_edge(r, l);
    @(negedge clk);
    cyc++;
    check("pll_resetb", bus_if.pll_resetb, e_pllrb);
    check("sys_reset",  bus_if.sys_reset,  e_sys);
    check("cpu_reset",  bus_if.cpu_reset,  e_cpu);
    check("ready",      bus_if.ready,      e_rdy);
    check("lock_lost",  bus_if.lock_lost,  e_lost);
    check("retries",    bus_if.retries,    e_ret);
    check("inv_cpu_without_sys", 32'(!bus_if.cpu_reset && bus_if.sys_reset), 0);
    check("inv_ready_vs_cpu", bus_if.ready, 32'(!bus_if.cpu_reset));
    check("inv_lost_twice", 32'(prev_lost && bus_if.lock_lost), 0);
    prev_lost = bus_if.lock_lost;
  endtask

  typedef struct {
    bit r; bit l; int n;
    bit pllrb; bit sys; bit cpu; bit rdy; bit lost; int ret;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int run_left;
    bit l;
    bit r;

    // {reset, locked, cycles, then expect: pll_resetb, sys, cpu, ready, lock_lost, retries}
    tbl.push_back('{1,0,3,   0,1,1,0,0,0});   // reset state
    tbl.push_back('{0,0,4,   0,1,1,0,0,0});   // clean start: 4-cycle PLL reset
    tbl.push_back('{0,0,1,   1,1,1,0,0,0});
    tbl.push_back('{0,0,4,   1,1,1,0,0,0});
    tbl.push_back('{0,1,10,  1,1,1,0,0,0});   // locked rises at cycle 10
    tbl.push_back('{0,1,1,   1,1,1,0,0,0});
    tbl.push_back('{0,1,1,   1,0,1,0,0,0});   // sys_reset released
    tbl.push_back('{0,1,4,   1,0,1,0,0,0});
    tbl.push_back('{0,1,1,   1,0,0,1,0,0});   // cpu_reset released 5 later
    tbl.push_back('{0,0,2,   1,0,0,1,0,0});   // loss in RUN: sync delay
    tbl.push_back('{0,0,1,   1,0,0,1,0,0});
    tbl.push_back('{0,0,1,   1,1,1,0,1,0});   // lock_lost pulse, resets asserted
    tbl.push_back('{0,0,1,   0,1,1,0,0,0});   // PLL reset next cycle
    tbl.push_back('{0,0,3,   0,1,1,0,0,0});
    tbl.push_back('{0,0,1,   1,1,1,0,0,0});
    tbl.push_back('{0,0,19,  1,1,1,0,0,0});   // no lock: timeout
    tbl.push_back('{0,0,1,   0,1,1,0,0,1});
    tbl.push_back('{0,0,3,   0,1,1,0,0,1});
    tbl.push_back('{0,0,1,   1,1,1,0,0,1});
    tbl.push_back('{0,0,19,  1,1,1,0,0,1});   // 24-cycle retry period
    tbl.push_back('{0,0,1,   0,1,1,0,0,2});
    tbl.push_back('{0,0,400, 1,1,1,0,0,15});  // retries saturate
    tbl.push_back('{1,1,1,   0,1,1,0,0,0});   // reset clears retries
    tbl.push_back('{0,1,14,  1,0,1,0,0,0});   // reach CPU_WAIT
    tbl.push_back('{1,1,1,   0,1,1,0,0,0});   // mid-operation reset
    tbl.push_back('{0,1,13,  1,1,1,0,0,0});
    tbl.push_back('{0,1,1,   1,0,1,0,0,0});
    tbl.push_back('{0,1,5,   1,0,0,1,0,0});   // full sequence repeats
    tbl.push_back('{1,1,1,   0,1,1,0,0,0});   // lock glitch in STABLE
    tbl.push_back('{0,1,8,   1,1,1,0,0,0});
    tbl.push_back('{0,0,1,   1,1,1,0,0,0});
    tbl.push_back('{0,1,11,  1,1,1,0,0,0});
    tbl.push_back('{0,1,1,   1,0,1,0,0,0});   // released 8 cycles after glitch
    tbl.push_back('{1,1,1,   0,1,1,0,0,0});   // drop as CPU_DELAY expires
    tbl.push_back('{0,1,15,  1,0,1,0,0,0});
    tbl.push_back('{0,0,3,   1,0,1,0,0,0});
    tbl.push_back('{0,0,1,   1,1,1,0,1,0});   // LOST wins, cpu_reset never drops
    tbl.push_back('{0,0,1,   0,1,1,0,0,0});

    reset = 1'b1;
    bus_if.locked = 1'b0;
    prev_lost = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) cycle(tbl[i].r, tbl[i].l);
      check($sformatf("row%0d pll_resetb", i), bus_if.pll_resetb, tbl[i].pllrb);
      check($sformatf("row%0d sys_reset", i),  bus_if.sys_reset,  tbl[i].sys);
      check($sformatf("row%0d cpu_reset", i),  bus_if.cpu_reset,  tbl[i].cpu);
      check($sformatf("row%0d ready", i),      bus_if.ready,      tbl[i].rdy);
      check($sformatf("row%0d lock_lost", i),  bus_if.lock_lost,  tbl[i].lost);
      check($sformatf("row%0d retries", i),    bus_if.retries,    tbl[i].ret);
    end

    // Random lock runs of varied length with occasional resets.
    cycle(1'b1, 1'b0);
    l = 1'b0;
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        l = !l;
        run_left = l ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 30));
      end
      run_left--;
      r = ($urandom_range(0, 499) == 0);
      cycle(r, l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
